// File: rtl/stream_width_downsizer_pkg.sv
// Shared constants and helpers for the byte-stream width converter.
package stream_width_downsizer_pkg;

  localparam int BYTE_W = 8;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/stream_width_downsizer.sv
// Byte-stream width converter: holds one IN_BYTES beat and drains it as
// OUT_BYTES-wide beats, low byte first, with zero-bubble hand-over to the next beat.
module stream_width_downsizer
  import stream_width_downsizer_pkg::*;
#(
  parameter int IN_BYTES  = 8,
  parameter int OUT_BYTES = 1,
  localparam int CW  = $clog2(IN_BYTES + 1),
  localparam int OCW = $clog2(OUT_BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        input_valid,
  output logic                        input_ready,
  input  logic [BYTE_W*IN_BYTES-1:0]  input_payload,
  input  logic [CW-1:0]               input_count,
  input  logic                        input_last,
  output logic                        output_valid,
  input  logic                        output_ready,
  output logic [BYTE_W*OUT_BYTES-1:0] output_payload,
  output logic [OCW-1:0]              output_count,
  output logic                        output_last
);

  if (OUT_BYTES < 1 || IN_BYTES < OUT_BYTES || (IN_BYTES % OUT_BYTES) != 0) begin : g_bad_ratio
    $fatal(1, "stream_width_downsizer: OUT_BYTES must divide IN_BYTES");
  end

  logic [BYTE_W*IN_BYTES-1:0] buf_data;
  logic [CW-1:0]              buf_cnt;
  logic                       buf_last;
  logic                       buf_valid;
  logic                       final_beat;
  logic                       in_fire;
  logic                       out_fire;

  assign final_beat = buf_cnt <= CW'(OUT_BYTES);
  // Ready is a combinational function of output_ready so the last output beat
  // and the next input beat can change hands on the same edge.
  assign input_ready = !buf_valid || (output_ready && final_beat);
  assign in_fire     = input_valid && input_ready;
  assign out_fire    = buf_valid && output_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_data  <= '0;
      buf_cnt   <= '0;
      buf_last  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (in_fire) begin
      buf_data  <= input_payload;
      buf_cnt   <= input_count;
      buf_last  <= input_last;
      buf_valid <= 1'b1;
    end else if (out_fire && !final_beat) begin
      buf_data  <= buf_data >> (BYTE_W * OUT_BYTES);
      buf_cnt   <= buf_cnt - CW'(OUT_BYTES);
    end else if (out_fire) begin
      buf_cnt   <= '0;
      buf_last  <= 1'b0;
      buf_valid <= 1'b0;
    end
  end

  assign output_valid   = buf_valid;
  assign output_payload = buf_data[BYTE_W*OUT_BYTES-1:0];
  assign output_count   = OCW'(min_int(int'(buf_cnt), OUT_BYTES));
  assign output_last    = buf_last && final_beat;

  a_count_legal : assert property (@(posedge clk) disable iff (rst)
    input_valid |-> (input_count != '0 && int'(input_count) <= IN_BYTES))
    else $error("stream_width_downsizer: illegal input_count %0d", input_count);

  a_input_stable : assert property (@(posedge clk) disable iff (rst)
    (input_valid && !input_ready) |=> (input_valid && $stable(input_payload)
                                       && $stable(input_count) && $stable(input_last)))
    else $error("stream_width_downsizer: input changed while stalled");

endmodule

// File: tb/tb_stream_width_downsizer.sv
// Directed and scoreboarded checks for the width downsizer at 8->1 and 8->4.
module tb_stream_width_downsizer;

  logic clk = 1'b0;
  logic rst;

  logic        a_in_valid, a_in_ready, a_in_last;
  logic [63:0] a_in_payload;
  logic [3:0]  a_in_count;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_out_payload;
  logic [0:0]  a_out_count;

  logic        b_in_valid, b_in_ready, b_in_last;
  logic [63:0] b_in_payload;
  logic [3:0]  b_in_count;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_out_payload;
  logic [2:0]  b_out_count;

  int n_cmp = 0;
  int n_bad = 0;

  initial forever #5 clk = ~clk;

  stream_width_downsizer #(.IN_BYTES(8), .OUT_BYTES(1)) u_8to1 (
    .clk(clk), .rst(rst),
    .input_valid(a_in_valid), .input_ready(a_in_ready), .input_payload(a_in_payload),
    .input_count(a_in_count), .input_last(a_in_last),
    .output_valid(a_out_valid), .output_ready(a_out_ready), .output_payload(a_out_payload),
    .output_count(a_out_count), .output_last(a_out_last)
  );

  stream_width_downsizer #(.IN_BYTES(8), .OUT_BYTES(4)) u_8to4 (
    .clk(clk), .rst(rst),
    .input_valid(b_in_valid), .input_ready(b_in_ready), .input_payload(b_in_payload),
    .input_count(b_in_count), .input_last(b_in_last),
    .output_valid(b_out_valid), .output_ready(b_out_ready), .output_payload(b_out_payload),
    .output_count(b_out_count), .output_last(b_out_last)
  );

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_payload = 64'h1111_1111_1111_1111; a_in_count = 4'd8; a_in_last = 1'b1;
    b_in_valid = 1'b1; b_in_payload = 64'h2222_2222_2222_2222; b_in_count = 4'd8; b_in_last = 1'b1;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({a_out_valid, b_out_valid, a_in_ready, b_in_ready} !== 4'b0011) begin
        n_bad++;
        $display("FAIL reset_hold: got v/v/r/r=%b want 0011",
                 {a_out_valid, b_out_valid, a_in_ready, b_in_ready});
      end
    end
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({a_out_valid, a_out_count, a_out_last, a_out_payload, a_in_ready} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_a: got v=%b c=%0d l=%b p=%h r=%b want 0 0 0 00 1",
               a_out_valid, a_out_count, a_out_last, a_out_payload, a_in_ready);
    end
    n_cmp++;
    if ({b_out_valid, b_out_count, b_out_last, b_out_payload, b_in_ready} !== {1'b0, 3'd0, 1'b0, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_b: got v=%b c=%0d l=%b p=%h r=%b want 0 0 0 00000000 1",
               b_out_valid, b_out_count, b_out_last, b_out_payload, b_in_ready);
    end
  endtask

  task automatic test_full_beat();
    @(negedge clk);
    a_in_valid = 1'b1; a_in_payload = 64'h0807_0605_0403_0201; a_in_count = 4'd8; a_in_last = 1'b1;
    a_out_ready = 1'b1; #1;
    n_cmp++;
    if (a_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL full_empty_ready: got %b want 1", a_in_ready);
    end
    @(negedge clk);
    a_in_payload = 64'h1817_1615_1413_1211; a_in_count = 4'd8; a_in_last = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({a_out_valid, a_out_payload, a_out_count, a_out_last, a_in_ready}
          !== {1'b1, 8'(i + 1), 1'b1, (i == 7), (i == 7)}) begin
        n_bad++;
        $display("FAIL full_byte%0d: got v=%b p=%h c=%0d l=%b r=%b want 1 %h 1 %b %b", i,
                 a_out_valid, a_out_payload, a_out_count, a_out_last, a_in_ready, 8'(i + 1), (i == 7), (i == 7));
      end
      @(negedge clk); #1;
    end
    a_in_valid = 1'b0; #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({a_out_valid, a_out_payload, a_out_count, a_out_last} !== {1'b1, 8'(8'h11 + i), 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL handover_byte%0d: got v=%b p=%h c=%0d l=%b want 1 %h 1 0", i,
                 a_out_valid, a_out_payload, a_out_count, a_out_last, 8'(8'h11 + i));
      end
      @(negedge clk); #1;
    end
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL full_drained: got valid=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_partial();
    @(negedge clk);
    a_in_valid = 1'b1; a_in_payload = 64'hAAAA_AAAA_AA03_0201; a_in_count = 4'd3; a_in_last = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({a_out_valid, a_out_payload, a_out_count, a_out_last} !== {1'b1, 8'(i + 1), 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL partial_byte%0d: got v=%b p=%h c=%0d l=%b want 1 %h 1 0", i,
                 a_out_valid, a_out_payload, a_out_count, a_out_last, 8'(i + 1));
      end
      @(negedge clk); #1;
    end
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL partial_drained: got valid=%b want 0 (leftover bytes)", a_out_valid);
    end
  endtask

  task automatic test_8to4();
    @(negedge clk);
    b_in_valid = 1'b1; b_in_payload = 64'h0807_0605_0403_0201; b_in_count = 4'd6; b_in_last = 1'b1;
    b_out_ready = 1'b0;
    @(negedge clk);
    b_in_valid = 1'b0; #1;
    repeat (2) begin
      n_cmp++;
      if ({b_out_valid, b_out_payload, b_out_count, b_out_last, b_in_ready}
          !== {1'b1, 32'h0403_0201, 3'd4, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL w4_stall: got v=%b p=%h c=%0d l=%b r=%b want 1 04030201 4 0 0",
                 b_out_valid, b_out_payload, b_out_count, b_out_last, b_in_ready);
      end
      @(negedge clk); #1;
    end
    b_out_ready = 1'b1; #1;
    n_cmp++;
    if ({b_out_valid, b_out_payload, b_out_count, b_out_last, b_in_ready}
        !== {1'b1, 32'h0403_0201, 3'd4, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL w4_first: got v=%b p=%h c=%0d l=%b r=%b want 1 04030201 4 0 0",
               b_out_valid, b_out_payload, b_out_count, b_out_last, b_in_ready);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({b_out_valid, b_out_payload[15:0], b_out_count, b_out_last, b_in_ready}
        !== {1'b1, 16'h0605, 3'd2, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL w4_second: got v=%b p=%h c=%0d l=%b r=%b want 1 ????0605 2 1 1",
               b_out_valid, b_out_payload, b_out_count, b_out_last, b_in_ready);
    end
    @(negedge clk); #1;
    n_cmp++;
    if (b_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL w4_drained: got valid=%b want 0", b_out_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    int         sent = 0;
    int         cycles = 0;
    bit         pend = 0;
    bit         stalled = 0;
    logic [7:0] hold_data = '0;
    logic       hold_last = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    while ((sent < 300 || pend || exp_data.size() != 0) && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      if (!pend) begin
        a_in_valid = 1'b0;
        if (sent < 300 && $urandom_range(0, 1) == 1) begin
          a_in_payload = {$urandom, $urandom};
          a_in_count   = 4'($urandom_range(1, 8));
          a_in_last    = ($urandom_range(0, 1) == 1);
          for (int unsigned k = 0; k < 32'(a_in_count); k++) begin
            exp_data.push_back(a_in_payload[8*k +: 8]);
            exp_last.push_back(a_in_last && (k == 32'(a_in_count) - 1));
          end
          sent++; pend = 1; a_in_valid = 1'b1;
        end
      end
      a_out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (stalled) begin
        n_cmp++;
        if ({a_out_valid, a_out_payload, a_out_last} !== {1'b1, hold_data, hold_last}) begin
          n_bad++;
          $display("FAIL rand_stable: got v=%b p=%h l=%b want 1 %h %b",
                   a_out_valid, a_out_payload, a_out_last, hold_data, hold_last);
        end
      end
      if (a_out_valid === 1'b1 && a_out_ready) begin
        n_cmp++;
        if (exp_data.size() == 0) begin
          n_bad++; $display("FAIL rand_extra: got byte %h want no output", a_out_payload);
        end else begin
          if ({a_out_payload, a_out_count, a_out_last} !== {exp_data[0], 1'b1, exp_last[0]}) begin
            n_bad++;
            $display("FAIL rand_byte: got p=%h c=%0d l=%b want %h 1 %b",
                     a_out_payload, a_out_count, a_out_last, exp_data[0], exp_last[0]);
          end
          void'(exp_data.pop_front());
          void'(exp_last.pop_front());
        end
      end
      stalled   = (a_out_valid === 1'b1) && !a_out_ready;
      hold_data = a_out_payload;
      hold_last = a_out_last;
      if (pend && a_in_ready === 1'b1) pend = 0;
    end
    n_cmp++;
    if (cycles >= 20000 || exp_data.size() != 0) begin
      n_bad++;
      $display("FAIL rand_complete: got cycles=%0d pending_bytes=%0d want <20000 and 0", cycles, exp_data.size());
    end
    @(negedge clk);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_payload = 64'h0807_0605_0403_0201; a_in_count = 4'd8; a_in_last = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({a_out_valid, a_out_payload} !== {1'b1, 8'h04}) begin
      n_bad++; $display("FAIL mid_before: got v=%b p=%h want 1 04", a_out_valid, a_out_payload);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if ({a_out_valid, a_out_last, a_in_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b l=%b r=%b want 0 0 1", a_out_valid, a_out_last, a_in_ready);
    end
    rst = 1'b0;
    a_in_valid = 1'b1; a_in_payload = 64'hEEEE_EEEE_EEC3_C2C1; a_in_count = 4'd3; a_in_last = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({a_out_valid, a_out_payload, a_out_count, a_out_last} !== {1'b1, 8'(8'hC1 + i), 1'b1, (i == 2)}) begin
        n_bad++;
        $display("FAIL mid_after%0d: got v=%b p=%h c=%0d l=%b want 1 %h 1 %b", i,
                 a_out_valid, a_out_payload, a_out_count, a_out_last, 8'(8'hC1 + i), (i == 2));
      end
      @(negedge clk); #1;
    end
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_drained: got valid=%b want 0", a_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_full_beat();
    test_partial();
    test_8to4();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
